reg4_share_arb: RTL and testbench



---
 rtl/reg4_share_arb.sv | 136 +++++++++++++
 tb/tb_reg4_share_arb.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/reg4_share_arb.sv
// reg4_share_arb
// Round-robin arbiter and write sequencer that shares one W-bit register
// between two requesters. A requester raises req, waits for gnt, writes
// with we strobes and drops req to release. A hold limit lets a waiting
// requester preempt an owner that has held the grant for MAX_HOLD cycles.
//
// Ports:
//   clk_i      in   1   clock, rising edge
//   rst_ni     in   1   asynchronous active-low reset
//   req_i      in   2   request per requester
//   we_i       in   2   write strobe per requester (only honoured with gnt)
//   wdata0_i   in   W   write data, requester 0
//   wdata1_i   in   W   write data, requester 1
//   gnt_o      out  2   registered grant, one-hot or zero
//   ack_o      out  2   registered one-cycle write acknowledge
//   q_o        out  W   shared register content
module reg4_share_arb #(
  parameter int W        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [1:0]   req_i,
  input  logic [1:0]   we_i,
  input  logic [W-1:0] wdata0_i,
  input  logic [W-1:0] wdata1_i,
  output logic [1:0]   gnt_o,
  output logic [1:0]   ack_o,
  output logic [W-1:0] q_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  // With preemption disabled the counter simply saturates at its top value.
  localparam bit         PREEMPT_EN = (MAX_HOLD > 0);
  localparam logic [7:0] HOLD_LAST  = (MAX_HOLD > 0) ? 8'(MAX_HOLD - 1) : 8'hFF;

  state_e         state_q, state_d;
  logic           last_q, last_d;   // last-served requester
  logic [7:0]     hold_q, hold_d;
  logic [1:0]     gnt_q, ack_q;
  logic [W-1:0]   data_q, data_d;
  logic [1:0]     wr_en;

  // Next-state decision
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        case (req_i)
          2'b01:   state_d = OWN0;
          2'b10:   state_d = OWN1;
          // Tie goes to whoever was not served last.
          2'b11:   state_d = last_q ? OWN0 : OWN1;
          default: state_d = IDLE;
        endcase
      end
      OWN0: begin
        if (!req_i[0]) begin
          last_d  = 1'b0;
          state_d = req_i[1] ? OWN1 : IDLE;
        end else if (PREEMPT_EN && (hold_q == HOLD_LAST) && req_i[1]) begin
          last_d  = 1'b0;
          state_d = OWN1;
        end
      end
      OWN1: begin
        if (!req_i[1]) begin
          last_d  = 1'b1;
          state_d = req_i[0] ? OWN0 : IDLE;
        end else if (PREEMPT_EN && (hold_q == HOLD_LAST) && req_i[0]) begin
          last_d  = 1'b1;
          state_d = OWN0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Hold counter: restarts on any state change, saturates otherwise so an
  // uncontested owner is never revoked.
  always_comb begin
    hold_d = hold_q;
    if (state_d != state_q) begin
      hold_d = 8'd0;
    end else if ((state_q != IDLE) && (hold_q != HOLD_LAST)) begin
      hold_d = hold_q + 8'd1;
    end
  end

  // A write is accepted only from the current grant holder; since gnt is
  // registered, a write on the revoking edge still completes.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_wr
      assign wr_en[gi] = gnt_q[gi] & we_i[gi];
    end
  endgenerate

  always_comb begin
    data_d = data_q;
    if (wr_en[1]) begin
      data_d = wdata1_i;
    end else if (wr_en[0]) begin
      data_d = wdata0_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      hold_q  <= 8'd0;
      gnt_q   <= 2'b00;
      ack_q   <= 2'b00;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      gnt_q   <= {state_d == OWN1, state_d == OWN0};
      ack_q   <= wr_en;
      data_q  <= data_d;
    end
  end

  assign gnt_o = gnt_q;
  assign ack_o = ack_q;
  assign q_o   = data_q;

endmodule

// File: tb/tb_reg4_share_arb.sv
// Bench for reg4_share_arb: instance A uses MAX_HOLD=3, instance B uses
// MAX_HOLD=0 (no preemption). Each step drives inputs, queues the expected
// outputs, clocks once and compares the popped expectation.
module tb_reg4_share_arb;

  logic       clk;
  logic       rst_n;
  logic [1:0] req_a, we_a, gnt_a, ack_a;
  logic [3:0] wd0_a, wd1_a, q_a;
  logic [1:0] req_b, we_b, gnt_b, ack_b;
  logic [3:0] wd0_b, wd1_b, q_b;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [1:0] gnt;
    logic [1:0] ack;
    logic [3:0] q;
  } exp_t;

  exp_t exp_q[$];

  reg4_share_arb #(.W(4), .MAX_HOLD(3)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_a), .we_i(we_a),
    .wdata0_i(wd0_a), .wdata1_i(wd1_a),
    .gnt_o(gnt_a), .ack_o(ack_a), .q_o(q_a)
  );

  reg4_share_arb #(.W(4), .MAX_HOLD(0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_b), .we_i(we_b),
    .wdata0_i(wd0_b), .wdata1_i(wd1_b),
    .gnt_o(gnt_b), .ack_o(ack_b), .q_o(q_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  // sel=0 drives instance A, sel=1 drives instance B.
  task automatic step(input bit sel, input string tag,
                      input logic [1:0] r, input logic [1:0] w,
                      input logic [3:0] d0, input logic [3:0] d1,
                      input logic [1:0] eg, input logic [1:0] ea, input logic [3:0] eq);
    exp_t e;
    if (!sel) begin
      req_a = r; we_a = w; wd0_a = d0; wd1_a = d1;
    end else begin
      req_b = r; we_b = w; wd0_b = d0; wd1_b = d1;
    end
    exp_q.push_back('{gnt: eg, ack: ea, q: eq});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    if (!sel) begin
      $display("step %s: req=%b we=%b gnt=%b ack=%b q=%h", tag, r, w, gnt_a, ack_a, q_a);
      check_val({tag, ".gnt"}, 32'(gnt_a), 32'(e.gnt));
      check_val({tag, ".ack"}, 32'(ack_a), 32'(e.ack));
      check_val({tag, ".q"},   32'(q_a),   32'(e.q));
    end else begin
      $display("step %s: req=%b we=%b gnt=%b ack=%b q=%h", tag, r, w, gnt_b, ack_b, q_b);
      check_val({tag, ".gnt"}, 32'(gnt_b), 32'(e.gnt));
      check_val({tag, ".ack"}, 32'(ack_b), 32'(e.ack));
      check_val({tag, ".q"},   32'(q_b),   32'(e.q));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_a = '0; we_a = '0; wd0_a = '0; wd1_a = '0;
    req_b = '0; we_b = '0; wd0_b = '0; wd1_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst.gnt", 32'(gnt_a), 32'h0);
    check_val("rst.ack", 32'(ack_a), 32'h0);
    check_val("rst.q",   32'(q_a),   32'h0);
    rst_n = 1'b1;

    // Basic grant, single write, ungranted strobes, release
    step(0, "idle_we",  2'b00, 2'b11, 4'h3, 4'hC, 2'b00, 2'b00, 4'h0);
    step(0, "grant0",   2'b01, 2'b00, 4'h0, 4'h0, 2'b01, 2'b00, 4'h0);
    step(0, "write0",   2'b01, 2'b01, 4'hA, 4'h0, 2'b01, 2'b01, 4'hA);
    step(0, "hold0",    2'b01, 2'b00, 4'h0, 4'h0, 2'b01, 2'b00, 4'hA);
    step(0, "ungrant",  2'b01, 2'b11, 4'h3, 4'hC, 2'b01, 2'b01, 4'h3);
    step(0, "wr1_ign",  2'b01, 2'b10, 4'h0, 4'hC, 2'b01, 2'b00, 4'h3);
    step(0, "release0", 2'b00, 2'b00, 4'h0, 4'h0, 2'b00, 2'b00, 4'h3);

    // Reset pulse between edges restores the tie pointer
    rst_n = 1'b0;
    #1;
    check_val("pulse.q", 32'(q_a), 32'h0);
    #1;
    rst_n = 1'b1;

    // Tie and round-robin
    step(0, "tie1",     2'b11, 2'b00, 4'h0, 4'h0, 2'b01, 2'b00, 4'h0);
    step(0, "handoff",  2'b10, 2'b00, 4'h0, 4'h0, 2'b10, 2'b00, 4'h0);
    step(0, "rel1",     2'b00, 2'b00, 4'h0, 4'h0, 2'b00, 2'b00, 4'h0);
    step(0, "tie2",     2'b11, 2'b00, 4'h0, 4'h0, 2'b01, 2'b00, 4'h0);
    step(0, "rel0",     2'b00, 2'b00, 4'h0, 4'h0, 2'b00, 2'b00, 4'h0);
    step(0, "tie3",     2'b11, 2'b00, 4'h0, 4'h0, 2'b10, 2'b00, 4'h0);
    step(0, "rel1b",    2'b00, 2'b00, 4'h0, 4'h0, 2'b00, 2'b00, 4'h0);

    // Preemption after 3 cycles, with a write on the revoking edge
    step(0, "pre_g0",   2'b01, 2'b00, 4'h0, 4'h0, 2'b01, 2'b00, 4'h0);
    step(0, "pre_c1",   2'b11, 2'b00, 4'h0, 4'h0, 2'b01, 2'b00, 4'h0);
    step(0, "pre_c2",   2'b11, 2'b00, 4'h0, 4'h0, 2'b01, 2'b00, 4'h0);
    step(0, "pre_lwr",  2'b11, 2'b01, 4'h5, 4'h0, 2'b10, 2'b01, 4'h5);
    step(0, "own1_wr",  2'b11, 2'b10, 4'h0, 4'hF, 2'b10, 2'b10, 4'hF);

    // Asynchronous reset mid-transaction
    rst_n = 1'b0;
    #1;
    check_val("arst.gnt", 32'(gnt_a), 32'h0);
    check_val("arst.ack", 32'(ack_a), 32'h0);
    check_val("arst.q",   32'(q_a),   32'h0);
    req_a = 2'b00; we_a = 2'b00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, "post_rst", 2'b11, 2'b00, 4'h0, 4'h0, 2'b01, 2'b00, 4'h0);
    step(0, "post_rel", 2'b00, 2'b00, 4'h0, 4'h0, 2'b00, 2'b00, 4'h0);

    // No preemption when MAX_HOLD=0
    step(1, "np_g0", 2'b01, 2'b00, 4'h0, 4'h0, 2'b01, 2'b00, 4'h0);
    for (int i = 0; i < 10; i++) begin
      step(1, $sformatf("np_hold%0d", i), 2'b11, 2'b00, 4'h0, 4'h0, 2'b01, 2'b00, 4'h0);
    end
    step(1, "np_hand", 2'b10, 2'b00, 4'h0, 4'h0, 2'b10, 2'b00, 4'h0);
    step(1, "np_rel",  2'b00, 2'b00, 4'h0, 4'h0, 2'b00, 2'b00, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
